// File: rtl/life_generation_engine.sv
// One Game-of-Life generation per start pulse. Rows stream through a three-row window.
// The current generation is read from bank rd_bank and the next is written to the other bank.
module life_generation_engine #(
    parameter int X_SIZE     = 1280,
    parameter int Y_SIZE     = 720,
    parameter int Y_WIDTH    = 10,
    parameter int RD_LATENCY = 1,
    parameter int WRAP       = 0
) (
    input  logic               out_stream_aclk,
    input  logic               periph_resetn,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               rd_bank,
    output logic [31:0]        gen_count,
    output logic               rd_en,
    output logic [Y_WIDTH-1:0] rd_addr,
    input  logic [X_SIZE-1:0]  rd_data,
    output logic               wr_en,
    output logic [Y_WIDTH-1:0] wr_addr,
    output logic [X_SIZE-1:0]  wr_data
);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_CALC, S_WRITE, S_DONE} state_t;
    typedef enum logic [1:0] {T_ABOVE, T_CUR, T_BELOW} tgt_t;

    localparam logic [Y_WIDTH-1:0] LAST_ROW = Y_WIDTH'(Y_SIZE - 1);
    localparam logic [Y_WIDTH:0]   ROWS     = (Y_WIDTH + 1)'(Y_SIZE);
    localparam logic [7:0]         LAT      = 8'(RD_LATENCY);
    localparam logic               WRAP_EN  = (WRAP != 0);

    state_t               state_q;
    tgt_t                 tgt_q;
    logic [7:0]           lat_q;
    logic [Y_WIDTH-1:0]   r_q;
    logic [X_SIZE-1:0]    above_q, cur_q, below_q;
    logic                 busy_q, done_q, rd_bank_q, rd_en_q, wr_en_q;
    logic [31:0]          gen_count_q;
    logic [Y_WIDTH-1:0]   rd_addr_q, wr_addr_q;
    logic [X_SIZE-1:0]    wr_data_q;

    logic [X_SIZE-1:0]    a_l, a_r, c_l, c_r, b_l, b_r, next_row_d;
    logic [3:0]           n;
    logic [Y_WIDTH:0]     r_plus2;

    assign r_plus2 = {1'b0, r_q} + (Y_WIDTH + 1)'(2);

    // Bit i's left neighbour is bit i+1, its right neighbour bit i-1.
    always_comb begin
        // NOTE: every comb output gets a value before the loop, so no latch can be inferred.
        a_l        = {WRAP_EN & above_q[0], above_q[X_SIZE-1:1]};
        a_r        = {above_q[X_SIZE-2:0], WRAP_EN & above_q[X_SIZE-1]};
        c_l        = {WRAP_EN & cur_q[0], cur_q[X_SIZE-1:1]};
        c_r        = {cur_q[X_SIZE-2:0], WRAP_EN & cur_q[X_SIZE-1]};
        b_l        = {WRAP_EN & below_q[0], below_q[X_SIZE-1:1]};
        b_r        = {below_q[X_SIZE-2:0], WRAP_EN & below_q[X_SIZE-1]};
        next_row_d = '0;
        n          = '0;
        for (int i = 0; i < X_SIZE; i++) begin
            n = {3'b0, a_l[i]} + {3'b0, above_q[i]} + {3'b0, a_r[i]}
              + {3'b0, c_l[i]} + {3'b0, c_r[i]}
              + {3'b0, b_l[i]} + {3'b0, below_q[i]} + {3'b0, b_r[i]};
            next_row_d[i] = (n == 4'd3) || (cur_q[i] && (n == 4'd2));
        end
    end

    always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            state_q     <= S_IDLE;
            tgt_q       <= T_ABOVE;
            lat_q       <= '0;
            r_q         <= '0;
            above_q     <= '0;
            cur_q       <= '0;
            below_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_bank_q   <= 1'b0;
            rd_en_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            gen_count_q <= '0;
            rd_addr_q   <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            // NOTE: non-blocking throughout, so every read sees the pre-edge value.
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        busy_q  <= 1'b1;
                        r_q     <= '0;
                        lat_q   <= '0;
                        rd_en_q <= 1'b1;
                        state_q <= S_FETCH;
                        if (WRAP_EN) begin
                            rd_addr_q <= LAST_ROW;
                            tgt_q     <= T_ABOVE;
                        end else begin
                            above_q   <= '0;
                            rd_addr_q <= '0;
                            tgt_q     <= T_CUR;
                        end
                    end
                end
                S_FETCH: begin
                    if (lat_q == LAT) begin
                        lat_q <= '0;
                        case (tgt_q)
                            T_ABOVE: begin
                                above_q   <= rd_data;
                                rd_en_q   <= 1'b1;
                                rd_addr_q <= '0;
                                tgt_q     <= T_CUR;
                            end
                            T_CUR: begin
                                cur_q     <= rd_data;
                                rd_en_q   <= 1'b1;
                                rd_addr_q <= Y_WIDTH'(1);
                                tgt_q     <= T_BELOW;
                            end
                            default: begin
                                below_q <= rd_data;
                                state_q <= S_CALC;
                            end
                        endcase
                    end else begin
                        lat_q <= lat_q + 8'd1;
                    end
                end
                S_CALC: begin
                    wr_data_q <= next_row_d;
                    wr_addr_q <= r_q;
                    wr_en_q   <= 1'b1;
                    state_q   <= S_WRITE;
                end
                S_WRITE: begin
                    if (r_q == LAST_ROW) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        above_q <= cur_q;
                        cur_q   <= below_q;
                        r_q     <= r_q + Y_WIDTH'(1);
                        // Row old_r+2 slides into the window; past the bottom it is dead or wraps.
                        if (r_plus2 < ROWS || WRAP_EN) begin
                            rd_addr_q <= (r_plus2 < ROWS) ? r_plus2[Y_WIDTH-1:0]
                                                          : Y_WIDTH'(r_plus2 - ROWS);
                            rd_en_q   <= 1'b1;
                            lat_q     <= '0;
                            tgt_q     <= T_BELOW;
                            state_q   <= S_FETCH;
                        end else begin
                            below_q <= '0;
                            state_q <= S_CALC;
                        end
                    end
                end
                S_DONE: begin
                    busy_q      <= 1'b0;
                    rd_bank_q   <= ~rd_bank_q;
                    gen_count_q <= gen_count_q + 32'd1;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign rd_bank   = rd_bank_q;
    assign gen_count = gen_count_q;
    assign rd_en     = rd_en_q;
    assign rd_addr   = rd_addr_q;
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;

endmodule

// File: tb/tb_life_generation_engine.sv
// Directed bench for life_generation_engine: three instances (no-wrap L=1, wrap L=1, no-wrap L=2)
// share one ping-pong line memory model; only the selected instance is started at a time.
module tb_life_generation_engine;

    localparam int X  = 1280;
    localparam int Y  = 720;
    localparam int YW = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start;
    logic [1:0] sel;
    logic [2:0] start_v;

    logic [2:0]         m_busy, m_done, m_rb, m_rd_en, m_wr_en;
    logic [2:0][31:0]   m_gen;
    logic [2:0][YW-1:0] m_rd_addr, m_wr_addr;
    logic [2:0][X-1:0]  m_wr_data;

    logic [X-1:0] stage1, stage2;
    logic [X-1:0] mem [2][Y];

    logic          clr_req, ld_en, ld_bank;
    logic [YW-1:0] ld_row;
    logic [X-1:0]  ld_data;

    int errors = 0;
    int checks = 0;
    int r_busy, r_done_at, r_ndone, r_nwr, r_bad, r_ovl;

    assign start_v = {sel == 2'd2, sel == 2'd1, sel == 2'd0} & {3{start}};

    life_generation_engine #(.X_SIZE(X), .Y_SIZE(Y), .Y_WIDTH(YW), .RD_LATENCY(1), .WRAP(0)) u_dut0 (
        .out_stream_aclk(clk), .periph_resetn(rst_n), .start(start_v[0]),
        .busy(m_busy[0]), .done(m_done[0]), .rd_bank(m_rb[0]), .gen_count(m_gen[0]),
        .rd_en(m_rd_en[0]), .rd_addr(m_rd_addr[0]), .rd_data(stage1),
        .wr_en(m_wr_en[0]), .wr_addr(m_wr_addr[0]), .wr_data(m_wr_data[0]));

    life_generation_engine #(.X_SIZE(X), .Y_SIZE(Y), .Y_WIDTH(YW), .RD_LATENCY(1), .WRAP(1)) u_dut1 (
        .out_stream_aclk(clk), .periph_resetn(rst_n), .start(start_v[1]),
        .busy(m_busy[1]), .done(m_done[1]), .rd_bank(m_rb[1]), .gen_count(m_gen[1]),
        .rd_en(m_rd_en[1]), .rd_addr(m_rd_addr[1]), .rd_data(stage1),
        .wr_en(m_wr_en[1]), .wr_addr(m_wr_addr[1]), .wr_data(m_wr_data[1]));

    life_generation_engine #(.X_SIZE(X), .Y_SIZE(Y), .Y_WIDTH(YW), .RD_LATENCY(2), .WRAP(0)) u_dut2 (
        .out_stream_aclk(clk), .periph_resetn(rst_n), .start(start_v[2]),
        .busy(m_busy[2]), .done(m_done[2]), .rd_bank(m_rb[2]), .gen_count(m_gen[2]),
        .rd_en(m_rd_en[2]), .rd_addr(m_rd_addr[2]), .rd_data(stage2),
        .wr_en(m_wr_en[2]), .wr_addr(m_wr_addr[2]), .wr_data(m_wr_data[2]));

    // Line memory: reads from the selected instance's rd_bank, writes to the other bank.
    always @(posedge clk) begin
        if (clr_req) begin
            for (int b = 0; b < 2; b++)
                for (int r = 0; r < Y; r++)
                    mem[b][r] <= '0;
        end else if (ld_en) begin
            mem[ld_bank][ld_row] <= ld_data;
        end else if (m_wr_en[sel]) begin
            mem[~m_rb[sel]][m_wr_addr[sel]] <= m_wr_data[sel];
        end
        if (m_rd_en[sel]) stage1 <= mem[m_rb[sel]][m_rd_addr[sel]];
        stage2 <= stage1;
    end

    function automatic logic [X-1:0] row_of(input int xa, input int xb, input int xc);
        logic [X-1:0] v;
        v = '0;
        if (xa >= 0) v[X-1-xa] = 1'b1;
        if (xb >= 0) v[X-1-xb] = 1'b1;
        if (xc >= 0) v[X-1-xc] = 1'b1;
        return v;
    endfunction

    function automatic int pop_bank(input logic b);
        int c;
        c = 0;
        for (int r = 0; r < Y; r++) c += $countones(mem[b][r]);
        return c;
    endfunction

    task automatic clear_mem();
        @(negedge clk); clr_req = 1'b1;
        @(negedge clk); clr_req = 1'b0;
    endtask

    task automatic set_cell(input logic b, input int x, input int y);
        logic [X-1:0] row;
        row        = mem[b][y];
        row[X-1-x] = 1'b1;
        ld_bank = b; ld_row = YW'(y); ld_data = row; ld_en = 1'b1;
        @(negedge clk); ld_en = 1'b0;
    endtask

    task automatic load_blinker(input logic b);
        clear_mem();
        for (int y = 10; y <= 12; y++) set_cell(b, 100, y);
    endtask

    // Pulses start on the selected instance and watches it until busy falls.
    task automatic run_gen(input logic extra);
        int cyc, next_row;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        r_busy = 0; r_done_at = 0; r_ndone = 0; r_nwr = 0; r_bad = 0; r_ovl = 0;
        cyc = 0; next_row = 0;
        while (m_busy[sel] && cyc < 10000) begin
            r_busy++;
            if (m_done[sel]) begin r_ndone++; r_done_at = r_busy; end
            if (m_wr_en[sel]) begin
                if (int'(m_wr_addr[sel]) != next_row) r_bad++;
                next_row++;
                r_nwr++;
            end
            if (m_rd_en[sel] && m_wr_en[sel]) r_ovl++;
            start = extra && (r_busy == 10 || r_busy == 2000);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        checks++;
        if (cyc >= 10000) begin
            errors++; $display("FAIL gen_timeout: still busy after %0d cycles, required idle", cyc);
        end
    endtask

    task automatic test_reset();
        int act;
        repeat (3) @(negedge clk);
        checks++;
        if ({m_busy, m_done, m_rb, m_rd_en, m_wr_en} !== 15'd0) begin
            errors++; $display("FAIL reset_flags: got %h required 0", {m_busy, m_done, m_rb, m_rd_en, m_wr_en});
        end
        checks++;
        if (m_gen !== '0) begin errors++; $display("FAIL reset_gen_count: got %h required 0", m_gen); end
        checks++;
        if ({m_rd_addr, m_wr_addr} !== '0) begin
            errors++; $display("FAIL reset_addr: got %h required 0", {m_rd_addr, m_wr_addr});
        end
        checks++;
        if (m_wr_data !== '0) begin
            errors++; $display("FAIL reset_wr_data: got ones=%0d required 0", $countones(m_wr_data));
        end
        rst_n = 1'b1;
        act = 0;
        repeat (5000) begin
            @(negedge clk);
            if ((m_rd_en | m_wr_en) != 3'b000) act++;
        end
        checks++;
        if (act != 0) begin errors++; $display("FAIL idle_strobes: got %0d active cycles required 0", act); end
    endtask

    task automatic test_blinker();
        sel = 2'd0;
        load_blinker(1'b0);
        run_gen(1'b0);
        checks++;
        if (r_busy != 2881) begin errors++; $display("FAIL blinker_busy_len: got %0d required 2881", r_busy); end
        checks++;
        if (r_done_at != 2881 || r_ndone != 1) begin
            errors++; $display("FAIL blinker_done: got cycle %0d count %0d required cycle 2881 count 1", r_done_at, r_ndone);
        end
        checks++;
        if (r_nwr != 720 || r_bad != 0) begin
            errors++; $display("FAIL blinker_writes: got %0d writes %0d out of order required 720 and 0", r_nwr, r_bad);
        end
        checks++;
        if (r_ovl != 0) begin errors++; $display("FAIL blinker_rd_wr_overlap: got %0d required 0", r_ovl); end
        checks++;
        if (mem[1][11] !== row_of(99, 100, 101)) begin
            errors++; $display("FAIL blinker_row11: got ones=%0d required ones=3 at x=99..101", $countones(mem[1][11]));
        end
        checks++;
        if (mem[1][10] !== '0 || mem[1][12] !== '0) begin
            errors++; $display("FAIL blinker_rows10_12: got ones=%0d/%0d required 0/0", $countones(mem[1][10]), $countones(mem[1][12]));
        end
        checks++;
        if (pop_bank(1'b1) != 3) begin errors++; $display("FAIL blinker_pop: got %0d required 3", pop_bank(1'b1)); end
        checks++;
        if (m_rb[0] !== 1'b1 || m_gen[0] !== 32'd1) begin
            errors++; $display("FAIL blinker_bank_count: got rd_bank=%0d gen=%0d required 1 and 1", m_rb[0], m_gen[0]);
        end
    endtask

    task automatic test_edges_nowrap();
        sel = 2'd0;
        clear_mem();
        set_cell(1'b1, 0, 0); set_cell(1'b1, 1, 0);
        set_cell(1'b1, 0, 1); set_cell(1'b1, 1, 1);
        set_cell(1'b1, 1279, 719);
        run_gen(1'b0);
        checks++;
        if (mem[0][0] !== row_of(0, 1, -1) || mem[0][1] !== row_of(0, 1, -1)) begin
            errors++; $display("FAIL edge_block: got ones=%0d/%0d required block at x=0..1", $countones(mem[0][0]), $countones(mem[0][1]));
        end
        checks++;
        if (mem[0][719] !== '0) begin
            errors++; $display("FAIL edge_lone_cell: got ones=%0d required 0", $countones(mem[0][719]));
        end
        checks++;
        if (pop_bank(1'b0) != 4) begin errors++; $display("FAIL edge_pop: got %0d required 4", pop_bank(1'b0)); end
        checks++;
        if (m_rb[0] !== 1'b0 || m_gen[0] !== 32'd2) begin
            errors++; $display("FAIL edge_bank_count: got rd_bank=%0d gen=%0d required 0 and 2", m_rb[0], m_gen[0]);
        end
    endtask

    task automatic test_glider_wrap();
        int bad_len;
        sel = 2'd1;
        clear_mem();
        set_cell(1'b0, 1279, 718);
        set_cell(1'b0, 0, 719);
        set_cell(1'b0, 1278, 0); set_cell(1'b0, 1279, 0); set_cell(1'b0, 0, 0);
        bad_len = 0;
        for (int g = 0; g < 4; g++) begin
            run_gen(1'b0);
            if (r_busy != 2885 || r_nwr != 720) bad_len++;
        end
        checks++;
        if (bad_len != 0) begin errors++; $display("FAIL glider_busy_len: got %0d bad gens required 0 (2885 cycles each)", bad_len); end
        checks++;
        if (mem[0][719] !== row_of(0, -1, -1)) begin
            errors++; $display("FAIL glider_row719: got ones=%0d required x=0", $countones(mem[0][719]));
        end
        checks++;
        if (mem[0][0] !== row_of(1, -1, -1)) begin
            errors++; $display("FAIL glider_row0: got ones=%0d required x=1", $countones(mem[0][0]));
        end
        checks++;
        if (mem[0][1] !== row_of(1279, 0, 1)) begin
            errors++; $display("FAIL glider_row1: got ones=%0d required x=1279,0,1", $countones(mem[0][1]));
        end
        checks++;
        if (pop_bank(1'b0) != 5) begin errors++; $display("FAIL glider_pop: got %0d required 5", pop_bank(1'b0)); end
        checks++;
        if (m_rb[1] !== 1'b0 || m_gen[1] !== 32'd4) begin
            errors++; $display("FAIL glider_bank_count: got rd_bank=%0d gen=%0d required 0 and 4", m_rb[1], m_gen[1]);
        end
    endtask

    task automatic test_start_ignored();
        int extra_busy;
        sel = 2'd0;
        load_blinker(1'b0);
        run_gen(1'b1);
        checks++;
        if (r_nwr != 720 || r_ndone != 1 || r_busy != 2881) begin
            errors++; $display("FAIL restart_ignored: got %0d writes %0d done %0d busy required 720 1 2881", r_nwr, r_ndone, r_busy);
        end
        extra_busy = 0;
        repeat (20) begin @(negedge clk); if (m_busy[0]) extra_busy++; end
        checks++;
        if (extra_busy != 0) begin errors++; $display("FAIL restart_queued: got %0d busy cycles required 0", extra_busy); end
        checks++;
        if (m_gen[0] !== 32'd3) begin errors++; $display("FAIL restart_gen_count: got %0d required 3", m_gen[0]); end
        checks++;
        if (mem[1][11] !== row_of(99, 100, 101)) begin
            errors++; $display("FAIL restart_row11: got ones=%0d required x=99..101", $countones(mem[1][11]));
        end
    endtask

    task automatic test_reset_mid_gen();
        int cyc;
        sel = 2'd0;
        load_blinker(1'b1);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 0;
        while (!(m_wr_en[0] && m_wr_addr[0] == YW'(301)) && cyc < 5000) begin
            @(negedge clk); cyc++;
        end
        checks++;
        if (cyc >= 5000) begin errors++; $display("FAIL midreset_wait: no write of row 301 after %0d cycles", cyc); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (m_wr_en[0] !== 1'b0 || m_rd_en[0] !== 1'b0) begin
            errors++; $display("FAIL midreset_strobes: got wr_en=%0d rd_en=%0d required 0 0", m_wr_en[0], m_rd_en[0]);
        end
        checks++;
        if (m_busy[0] !== 1'b0 || m_rb[0] !== 1'b0 || m_gen[0] !== 32'd0) begin
            errors++; $display("FAIL midreset_state: got busy=%0d rd_bank=%0d gen=%0d required 0 0 0", m_busy[0], m_rb[0], m_gen[0]);
        end
        @(negedge clk); rst_n = 1'b1;
        load_blinker(1'b0);
        run_gen(1'b0);
        checks++;
        if (mem[1][11] !== row_of(99, 100, 101) || pop_bank(1'b1) != 3) begin
            errors++; $display("FAIL midreset_regen: got row11 ones=%0d pop=%0d required 3 and 3", $countones(mem[1][11]), pop_bank(1'b1));
        end
        checks++;
        if (m_rb[0] !== 1'b1 || m_gen[0] !== 32'd1 || r_nwr != 720) begin
            errors++; $display("FAIL midreset_count: got rd_bank=%0d gen=%0d writes=%0d required 1 1 720", m_rb[0], m_gen[0], r_nwr);
        end
    endtask

    task automatic test_latency2();
        sel = 2'd2;
        load_blinker(1'b0);
        run_gen(1'b0);
        checks++;
        if (r_busy != 3601 || r_done_at != 3601) begin
            errors++; $display("FAIL lat2_busy_len: got busy %0d done at %0d required 3601", r_busy, r_done_at);
        end
        checks++;
        if (mem[1][11] !== row_of(99, 100, 101) || pop_bank(1'b1) != 3) begin
            errors++; $display("FAIL lat2_result: got row11 ones=%0d pop=%0d required 3 and 3", $countones(mem[1][11]), pop_bank(1'b1));
        end
        checks++;
        if (r_nwr != 720 || r_bad != 0 || r_ovl != 0) begin
            errors++; $display("FAIL lat2_writes: got %0d writes %0d misordered %0d overlap required 720 0 0", r_nwr, r_bad, r_ovl);
        end
        checks++;
        if (m_rb[2] !== 1'b1 || m_gen[2] !== 32'd1) begin
            errors++; $display("FAIL lat2_bank_count: got rd_bank=%0d gen=%0d required 1 and 1", m_rb[2], m_gen[2]);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        sel     = 2'd0;
        clr_req = 1'b0;
        ld_en   = 1'b0;
        ld_bank = 1'b0;
        ld_row  = '0;
        ld_data = '0;
        test_reset();
        test_blinker();
        test_edges_nowrap();
        test_glider_wrap();
        test_start_ignored();
        test_reset_mid_gen();
        test_latency2();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
